video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_pkg.sv | 25 ++
 rtl/video_timing_gen_if.sv | 22 ++
 rtl/video_timing_gen_mod_counter.sv | 36 +++
 rtl/video_timing_gen.sv | 111 +++++++++++
 tb/tb_video_timing_gen.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared timing constants, types and decode helper for video_timing_gen
package video_timing_pkg;

    localparam int CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;

    // 640x480@60 defaults
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int HSYNC_BIT = 0;
    localparam int VSYNC_BIT = 1;

    // Half-open window test lo <= val < hi on 11-bit unsigned values.
    function automatic logic in_window(cnt_t val, cnt_t lo, cnt_t hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - pixel enable and timing/pixel outputs of video_timing_gen
interface video_timing_gen_if;
    import video_timing_pkg::*;

    logic       pix_en;
    cnt_t       hcount;
    cnt_t       vcount;
    logic       VDE;
    logic [1:0] CD;
    logic [7:0] VD;
    logic       frame_start;

    modport master (
        input  pix_en,
        output hcount, vcount, VDE, CD, VD, frame_start
    );

    modport slave (
        output pix_en,
        input  hcount, vcount, VDE, CD, VD, frame_start
    );
endinterface

// File: rtl/video_timing_gen_mod_counter.sv
// rtl/video_timing_gen_mod_counter.sv - enabled modulo counter exposing its next value for look-ahead decode
module mod_counter #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_max,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_next,
    output logic         o_wrap
);

    logic [W-1:0] r_count;
    logic         w_at_max;

    assign w_at_max = (r_count == i_max);
    assign o_wrap   = i_en && w_at_max;
    assign o_count  = r_count;

    always_comb begin
        o_next = r_count;
        if (i_en) begin
            o_next = w_at_max ? '0 : r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= o_next;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster counters with registered VDE/CD/VD/frame_start decoded from next position
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    video_timing_gen_if.master vif
);

    localparam cnt_t H_MAX       = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_MAX       = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t H_ACT       = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT       = cnt_t'(V_ACTIVE);
    localparam cnt_t H_SYNC_LO   = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t H_SYNC_HI   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t V_SYNC_LO   = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t V_SYNC_HI   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [1:0] CD_IDLE = {~SYNC_POL, ~SYNC_POL};

    cnt_t       w_hcount;
    cnt_t       w_vcount;
    cnt_t       w_h_next;
    cnt_t       w_v_next;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_v_en;

    logic       w_vde;
    logic [1:0] w_cd;
    logic [7:0] w_vd;
    logic       w_fs;

    logic       r_vde;
    logic [1:0] r_cd;
    logic [7:0] r_vd;
    logic       r_fs;

    assign w_v_en = vif.pix_en && w_h_wrap;

    mod_counter #(.W(CNT_W)) u_hcnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (vif.pix_en),
        .i_max   (H_MAX),
        .o_count (w_hcount),
        .o_next  (w_h_next),
        .o_wrap  (w_h_wrap)
    );

    mod_counter #(.W(CNT_W)) u_vcnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_v_en),
        .i_max   (V_MAX),
        .o_count (w_vcount),
        .o_next  (w_v_next),
        .o_wrap  (w_v_wrap)
    );

    // Decoding the counters' next values lets the registered outputs land on the same edge as the counters.
    always_comb begin
        w_vde = (w_h_next < H_ACT) && (w_v_next < V_ACT);
        w_cd  = CD_IDLE;
        if (in_window(w_h_next, H_SYNC_LO, H_SYNC_HI)) begin
            w_cd[HSYNC_BIT] = SYNC_POL;
        end
        if (in_window(w_v_next, V_SYNC_LO, V_SYNC_HI)) begin
            w_cd[VSYNC_BIT] = SYNC_POL;
        end
        w_vd  = w_vde ? (w_h_next[7:0] ^ w_v_next[7:0]) : 8'h00;
        w_fs  = (w_h_next == '0) && (w_v_next == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vde <= 1'b0;
            r_cd  <= CD_IDLE;
            r_vd  <= 8'h00;
            r_fs  <= 1'b0;
        end else if (vif.pix_en) begin
            r_vde <= w_vde;
            r_cd  <= w_cd;
            r_vd  <= w_vd;
            r_fs  <= w_fs;
        end else begin
            r_fs  <= 1'b0;
        end
    end

    assign vif.hcount      = w_hcount;
    assign vif.vcount      = w_vcount;
    assign vif.VDE         = r_vde;
    assign vif.CD          = r_cd;
    assign vif.VD          = r_vd;
    assign vif.frame_start = r_fs;

    // Frame wrap is implied by both counters returning to zero; the flag itself is not needed.
    logic w_unused;
    assign w_unused = w_v_wrap;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - table-driven and scoreboard checks of video_timing_gen with small timing
module tb_video_timing_gen;
    import video_timing_pkg::*;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        vde;
        logic [1:0]  cd;
        logic [7:0]  vd;
        logic        fs;
    } out_t;

    typedef struct {
        int   n;
        out_t exp;
    } vec_t;

    logic clk;
    logic rst;
    video_timing_gen_if vif();

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vif (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    int   m_h = 0;
    int   m_v = 0;
    out_t m_last;
    out_t last_got;
    out_t sb_q[$];
    vec_t vecs[14];

    function automatic out_t mk(int h, int v, logic vde, logic [1:0] cd, logic [7:0] vd, logic fs);
        out_t o;
        o.h = 11'(h); o.v = 11'(v); o.vde = vde; o.cd = cd; o.vd = vd; o.fs = fs;
        return o;
    endfunction

    function automatic out_t model_out(int h, int v, logic fs);
        out_t o;
        logic hs, vs;
        o.h   = 11'(h);
        o.v   = 11'(v);
        o.vde = (h < 8) && (v < 4);
        hs    = (h >= 10 && h <= 12) ? 1'b0 : 1'b1;
        vs    = (v == 5 || v == 6) ? 1'b0 : 1'b1;
        o.cd  = {vs, hs};
        o.vd  = o.vde ? 8'(h ^ v) : 8'h00;
        o.fs  = fs;
        return o;
    endfunction

    function automatic out_t dut_out();
        return {vif.hcount, vif.vcount, vif.VDE, vif.CD, vif.VD, vif.frame_start};
    endfunction

    function automatic void check(string name, out_t got, out_t exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got h=%0d v=%0d vde=%b cd=%b vd=%h fs=%b, expected h=%0d v=%0d vde=%b cd=%b vd=%h fs=%b",
                      name, got.h, got.v, got.vde, got.cd, got.vd, got.fs,
                      exp.h, exp.v, exp.vde, exp.cd, exp.vd, exp.fs);
    endfunction

    function automatic void check_int(string name, int got, int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endfunction

    task automatic step(input logic en, input logic r, input string name);
        out_t got, exp;
        rst = r;
        vif.pix_en = en;
        if (r) begin
            m_h = 0; m_v = 0;
            m_last = mk(0, 0, 1'b0, 2'b11, 8'h00, 1'b0);
        end else if (en) begin
            m_h++;
            if (m_h == 16) begin
                m_h = 0;
                m_v = (m_v == 7) ? 0 : m_v + 1;
            end
            m_last = model_out(m_h, m_v, (m_h == 0) && (m_v == 0));
        end else begin
            m_last.fs = 1'b0;
        end
        sb_q.push_back(m_last);
        @(posedge clk);
        #1;
        got = dut_out();
        last_got = got;
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            exp = sb_q.pop_front();
            check(name, got, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int fs_cnt;
        out_t rst_val;
        rst_val = mk(0, 0, 1'b0, 2'b11, 8'h00, 1'b0);

        vecs[0]  = '{1,   mk(1, 0, 1, 2'b11, 8'h01, 0)};
        vecs[1]  = '{3,   mk(3, 0, 1, 2'b11, 8'h03, 0)};
        vecs[2]  = '{7,   mk(7, 0, 1, 2'b11, 8'h07, 0)};
        vecs[3]  = '{8,   mk(8, 0, 0, 2'b11, 8'h00, 0)};
        vecs[4]  = '{10,  mk(10, 0, 0, 2'b10, 8'h00, 0)};
        vecs[5]  = '{12,  mk(12, 0, 0, 2'b10, 8'h00, 0)};
        vecs[6]  = '{13,  mk(13, 0, 0, 2'b11, 8'h00, 0)};
        vecs[7]  = '{15,  mk(15, 0, 0, 2'b11, 8'h00, 0)};
        vecs[8]  = '{16,  mk(0, 1, 1, 2'b11, 8'h01, 0)};
        vecs[9]  = '{53,  mk(5, 3, 1, 2'b11, 8'h06, 0)};
        vecs[10] = '{82,  mk(2, 5, 0, 2'b01, 8'h00, 0)};
        vecs[11] = '{107, mk(11, 6, 0, 2'b00, 8'h00, 0)};
        vecs[12] = '{127, mk(15, 7, 0, 2'b11, 8'h00, 0)};
        vecs[13] = '{128, mk(0, 0, 1, 2'b11, 8'h00, 1)};

        rst = 1'b1;
        vif.pix_en = 1'b1;

        // Reset for cycles 0 and 1, released at cycle 2.
        step(1'b1, 1'b1, "reset_c0");
        step(1'b1, 1'b1, "reset_c1");
        check("reset_state", last_got, rst_val);

        fs_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b0, "run");
            if (i == 0) check("first_after_rst", last_got, mk(1, 0, 1, 2'b11, 8'h01, 0));
            if (i == 15) check("hwrap_vstep", last_got, mk(0, 1, 1, 2'b11, 8'h01, 0));
            if (last_got.fs) fs_cnt++;
        end
        check_int("frame_start_count", fs_cnt, 2);

        foreach (vecs[k]) begin
            step(1'b0, 1'b1, "vec_reset");
            check("vec_reset_hold", last_got, rst_val);
            step(1'b0, 1'b0, "vec_release");
            for (int i = 0; i < vecs[k].n; i++) step(1'b1, 1'b0, "vec_run");
            check($sformatf("vec_n%0d", vecs[k].n), last_got, vecs[k].exp);
        end

        step(1'b1, 1'b1, "pulse_reset");
        for (int i = 0; i < 50; i++) step((i % 10) == 0, 1'b0, "pulse_run");
        check("pulse_pos", last_got, mk(5, 0, 1, 2'b11, 8'h05, 0));

        step(1'b1, 1'b1, "mid_reset_pre");
        for (int i = 0; i < 37; i++) step(1'b1, 1'b0, "mid_run");
        check("mid_pos", last_got, mk(5, 2, 1, 2'b11, 8'h07, 0));
        step(1'b1, 1'b1, "mid_reset");
        check("mid_reset_vals", last_got, rst_val);
        step(1'b1, 1'b0, "mid_restart");
        check("mid_restart_pos", last_got, mk(1, 0, 1, 2'b11, 8'h01, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
